module_seg7_scan: RTL and testbench

MODULE_SEG7_SCAN -- requirements
Module: module_seg7_scan

---
 rtl/module_seg7_scan.sv | 116 +++++++++++
 tb/tb_module_seg7_scan.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/module_seg7_scan.sv
// Multiplexed seven-segment scanner: cycles through NUM_DIGITS shadowed digit values,
// with a per-dwell anode-off ghost window and a one-cycle frame pulse per full scan.
module module_seg7_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_WIDTH    = 4,
    parameter int REFRESH_CYCLES = 50000,
    parameter int GHOST_CYCLES   = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                en_i,
    input  logic                                load_i,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0]   data_i,
    input  logic [NUM_DIGITS-1:0]               blank_i,
    output logic [NUM_DIGITS-1:0]               an_o,
    output logic [6:0]                          seg_o,
    output logic [DIGIT_WIDTH-1:0]              digit_o,
    output logic [$clog2(NUM_DIGITS)-1:0]       sel_o,
    output logic                                frame_o
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [IW-1:0]                        idx_q, idx_d;
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0]    data_q, data_d;
    logic [NUM_DIGITS-1:0]                blank_q, blank_d;
    logic                                 en_q, en_d;
    logic                                 frame_q, frame_d;

    logic [DIGIT_WIDTH-1:0]               digits [NUM_DIGITS];
    logic                                 ghost;
    logic                                 dark;

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = 1'b0;
        en_d    = en_i;
        data_d  = load_i ? data_i  : data_q;
        blank_d = load_i ? blank_i : blank_q;
        if (!en_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            frame_d = (idx_q == IDX_LAST);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            blank_q <= '1;
            en_q    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            blank_q <= blank_d;
            en_q    <= en_d;
            frame_q <= frame_d;
        end
    end

    // Ghost window keeps anodes off while the segment lines settle on the new digit.
    if (GHOST_CYCLES == 0) begin : g_no_ghost
        assign ghost = 1'b0;
    end else begin : g_ghost
        assign ghost = (cnt_q < CW'(GHOST_CYCLES));
    end

    assign dark = !en_q || ghost || blank_q[idx_q];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digits[gi] = data_q[gi*DIGIT_WIDTH +: DIGIT_WIDTH];
        assign an_o[gi]   = dark || (idx_q != IW'(gi));
    end

    assign digit_o = digits[idx_q];
    assign sel_o   = idx_q;
    assign frame_o = frame_q;

    always_comb begin
        seg_o = 7'b1111111;
        case (digit_o[3:0])
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_module_seg7_scan.sv
// Directed bench for module_seg7_scan: a 4-digit instance driven from a cycle table,
// plus a 3-digit, no-ghost instance exercising non-power-of-two wrap and async reset.
module tb_module_seg7_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_DIGITS=4, REFRESH_CYCLES=4, GHOST_CYCLES=1
    logic        rst_a, en_a, ld_a;
    logic [15:0] data_a;
    logic [3:0]  blank_a, an_a;
    logic [6:0]  seg_a;
    logic [3:0]  dig_a;
    logic [1:0]  sel_a;
    logic        frame_a;

    module_seg7_scan #(.NUM_DIGITS(4), .DIGIT_WIDTH(4), .REFRESH_CYCLES(4), .GHOST_CYCLES(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_a), .en_i(en_a), .load_i(ld_a), .data_i(data_a),
        .blank_i(blank_a), .an_o(an_a), .seg_o(seg_a), .digit_o(dig_a), .sel_o(sel_a),
        .frame_o(frame_a));

    // Instance B: NUM_DIGITS=3, REFRESH_CYCLES=2, GHOST_CYCLES=0
    logic        rst_b, en_b, ld_b;
    logic [11:0] data_b;
    logic [2:0]  blank_b, an_b;
    logic [6:0]  seg_b;
    logic [3:0]  dig_b;
    logic [1:0]  sel_b;
    logic        frame_b;

    module_seg7_scan #(.NUM_DIGITS(3), .DIGIT_WIDTH(4), .REFRESH_CYCLES(2), .GHOST_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_b), .en_i(en_b), .load_i(ld_b), .data_i(data_b),
        .blank_i(blank_b), .an_o(an_b), .seg_o(seg_b), .digit_o(dig_b), .sel_o(sel_b),
        .frame_o(frame_b));

    int passed = 0;
    int total  = 0;

    logic [6:0] seg_ref [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] data;
        logic [3:0]  blank;
        logic [3:0]  an;
        logic [1:0]  sel;
        logic [3:0]  dig;
        logic        frame;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic en, input logic ld, input logic [15:0] data,
                                input logic [3:0] blank, input logic [3:0] an,
                                input logic [1:0] sel, input logic [3:0] dig, input logic frame);
        vec_t v;
        v.en = en; v.ld = ld; v.data = data; v.blank = blank;
        v.an = an; v.sel = sel; v.dig = dig; v.frame = frame;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Instance B expected values after each of 12 edges, data 12'h321 loaded on edge 1
    logic [1:0] b_sel [12] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    logic [2:0] b_an  [12] = '{3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110,
                               3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110};
    logic       b_fr  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    localparam logic [15:0] D1 = 16'h4321;
    localparam logic [15:0] D2 = 16'hC9E7;

    initial begin
        rst_a = 1'b1; en_a = 1'b1; ld_a = 1'b0; data_a = '0; blank_a = '0;
        rst_b = 1'b1; en_b = 1'b0; ld_b = 1'b0; data_b = '0; blank_b = '0;
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("rst_an", an_a, 4'b1111);
        chk("rst_sel", sel_a, 2'd0);
        chk("rst_digit", dig_a, 4'd0);
        chk("rst_seg", seg_a, 7'b1000000);
        chk("rst_frame", frame_a, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_hold_an", an_a, 4'b1111);
        chk("rst_hold_sel", sel_a, 2'd0);
        rst_a = 1'b1; rst_b = 1'b1;

        // No load after reset: shadow blank is all ones, frame every 16 cycles
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            chk("noload_an", an_a, 4'b1111);
            chk("noload_frame", frame_a, (k % 16 == 0) ? 1'b1 : 1'b0);
            $display("noload cycle %0d: an=%b sel=%0d frame=%b", k, an_a, sel_a, frame_a);
        end

        add(1,1,D1,4'b0000, 4'b1110,0,4'h1,0);
        add(1,0,D1,4'b0000, 4'b1110,0,4'h1,0);
        add(1,0,D1,4'b0000, 4'b1110,0,4'h1,0);
        add(1,0,D1,4'b0000, 4'b1111,1,4'h2,0);
        add(1,0,D1,4'b0000, 4'b1101,1,4'h2,0);
        add(1,0,D1,4'b0000, 4'b1101,1,4'h2,0);
        add(1,0,D1,4'b0000, 4'b1101,1,4'h2,0);
        add(1,0,D1,4'b0000, 4'b1111,2,4'h3,0);
        add(1,0,D1,4'b0000, 4'b1011,2,4'h3,0);
        add(1,0,D1,4'b0000, 4'b1011,2,4'h3,0);
        add(1,0,D1,4'b0000, 4'b1011,2,4'h3,0);
        add(1,0,D1,4'b0000, 4'b1111,3,4'h4,0);
        add(1,0,D1,4'b0000, 4'b0111,3,4'h4,0);
        add(1,0,D1,4'b0000, 4'b0111,3,4'h4,0);
        add(1,0,D1,4'b0000, 4'b0111,3,4'h4,0);
        add(1,0,D1,4'b0000, 4'b1111,0,4'h1,1);
        add(1,0,D1,4'b0000, 4'b1110,0,4'h1,0);
        add(1,0,D1,4'b0000, 4'b1110,0,4'h1,0);
        add(1,0,D1,4'b0000, 4'b1110,0,4'h1,0);
        add(1,0,D1,4'b0000, 4'b1111,1,4'h2,0);
        add(1,0,D1,4'b0000, 4'b1101,1,4'h2,0);
        add(1,0,D1,4'b0000, 4'b1101,1,4'h2,0);
        add(1,0,D1,4'b0000, 4'b1101,1,4'h2,0);
        add(1,1,D2,4'b0000, 4'b1111,2,4'h9,0);  // load on the 1->2 switch edge
        add(1,0,D2,4'b0000, 4'b1011,2,4'h9,0);
        add(1,1,D2,4'b0100, 4'b1111,2,4'h9,0);  // digit 2 blanked
        add(1,0,D2,4'b0100, 4'b1111,2,4'h9,0);
        add(1,0,D2,4'b0100, 4'b1111,3,4'hC,0);
        add(1,0,D2,4'b0100, 4'b0111,3,4'hC,0);
        add(1,0,D2,4'b0100, 4'b0111,3,4'hC,0);
        add(1,0,D2,4'b0100, 4'b0111,3,4'hC,0);
        add(1,0,D2,4'b0100, 4'b1111,0,4'h7,1);
        add(1,0,D2,4'b0100, 4'b1110,0,4'h7,0);
        add(1,0,D2,4'b0100, 4'b1110,0,4'h7,0);
        add(1,0,D2,4'b0100, 4'b1110,0,4'h7,0);
        add(1,0,D2,4'b0100, 4'b1111,1,4'hE,0);
        add(1,0,D2,4'b0100, 4'b1101,1,4'hE,0);
        add(1,0,D2,4'b0100, 4'b1101,1,4'hE,0);
        add(1,0,D2,4'b0100, 4'b1101,1,4'hE,0);
        add(1,0,D2,4'b0100, 4'b1111,2,4'h9,0);
        add(1,0,D2,4'b0100, 4'b1111,2,4'h9,0);
        add(0,0,D2,4'b0100, 4'b1111,0,4'h7,0);  // enable dropped mid-dwell of digit 2
        add(0,0,D2,4'b0100, 4'b1111,0,4'h7,0);
        add(1,0,D2,4'b0100, 4'b1110,0,4'h7,0);
        add(1,0,D2,4'b0100, 4'b1110,0,4'h7,0);

        foreach (tbl[i]) begin
            en_a = tbl[i].en; ld_a = tbl[i].ld; data_a = tbl[i].data; blank_a = tbl[i].blank;
            @(posedge clk); #1;
            chk("tbl_an", an_a, tbl[i].an);
            chk("tbl_sel", sel_a, tbl[i].sel);
            chk("tbl_digit", dig_a, tbl[i].dig);
            chk("tbl_seg", seg_a, seg_ref[tbl[i].dig]);
            chk("tbl_frame", frame_a, tbl[i].frame);
            $display("row %0d: an=%b sel=%0d digit=%h seg=%b frame=%b", i, an_a, sel_a, dig_a, seg_a, frame_a);
        end

        // Glyph sweep: every digit holds the same value, so idx does not matter
        for (int v = 0; v < 16; v++) begin
            logic [3:0] nib;
            nib = 4'(v);
            en_a = 1'b1; ld_a = 1'b1; blank_a = '0; data_a = {4{nib}};
            @(posedge clk); #1;
            chk("glyph_digit", dig_a, nib);
            chk("glyph_seg", seg_a, seg_ref[v]);
            $display("glyph %h: seg=%b", dig_a, seg_a);
        end
        ld_a = 1'b0;

        // Instance B: three digits, two-cycle dwell, no ghost window
        chk("b_idle_sel", sel_b, 2'd0);
        chk("b_idle_an", an_b, 3'b111);
        en_b = 1'b1; ld_b = 1'b1; data_b = 12'h321; blank_b = 3'b000;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            ld_b = 1'b0;
            chk("b_sel", sel_b, b_sel[k]);
            chk("b_an", an_b, b_an[k]);
            chk("b_frame", frame_b, b_fr[k]);
            chk("b_digit", dig_b, 4'(b_sel[k]) + 4'd1);
            $display("b edge %0d: sel=%0d an=%b frame=%b digit=%h", k + 1, sel_b, an_b, frame_b, dig_b);
        end
        #2;
        rst_b = 1'b0;
        #1;
        chk("b_async_frame", frame_b, 1'b0);
        chk("b_async_sel", sel_b, 2'd0);
        chk("b_async_an", an_b, 3'b111);
        chk("b_async_digit", dig_b, 4'd0);
        chk("b_async_seg", seg_b, 7'b1000000);
        $display("b async reset: sel=%0d an=%b frame=%b seg=%b", sel_b, an_b, frame_b, seg_b);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("b_post_sel0", sel_b, 2'd0);
        chk("b_post_an0", an_b, 3'b111);
        @(posedge clk); #1;
        chk("b_post_sel1", sel_b, 2'd1);
        chk("b_post_an1", an_b, 3'b111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
